// File: rtl/dsp_mac_array.sv
// dsp_mac_array: packed-lane multiply-accumulate engine.
// Weights arrive over the SPI-side port, data over the Wishbone-side port.
// A command loads LEN bus words into each buffer, then streams them through a
// read -> lane-product-sum -> saturating-accumulate pipeline and pulses
// o_CONV_ACK when the result is ready.
// Ports:
//   i_CLK, i_RST                   clock, synchronous active-high reset
//   i_START, i_LEN, i_SIGNED,
//   i_KEEP_WEIGHTS, i_ACC_CLEAR    command and its configuration (sampled in IDLE)
//   i_SPI_VALID/i_SPI_DATA         weight words, accepted while o_WEIGHT_ACK=1
//   i_WISH_VALID/i_WISH_DATA       data words, accepted while o_DATA_ACK=1
//   o_CONV_ACK, o_BUSY, o_OVF      done pulse, busy, sticky saturation flag
//   o_WISH_DATA, o_SPI_DATA        result (same value on both)
module dsp_mac_array #(
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned OUTPUT_WIDTH  = 32
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_START,
  input  logic [ADDRESS_WIDTH:0]   i_LEN,
  input  logic                     i_SIGNED,
  input  logic                     i_KEEP_WEIGHTS,
  input  logic                     i_ACC_CLEAR,
  input  logic                     i_SPI_VALID,
  input  logic [BUS_WIDTH-1:0]     i_SPI_DATA,
  input  logic                     i_WISH_VALID,
  input  logic [BUS_WIDTH-1:0]     i_WISH_DATA,
  output logic                     o_WEIGHT_ACK,
  output logic                     o_DATA_ACK,
  output logic                     o_CONV_ACK,
  output logic                     o_BUSY,
  output logic                     o_OVF,
  output logic [OUTPUT_WIDTH-1:0]  o_WISH_DATA,
  output logic [OUTPUT_WIDTH-1:0]  o_SPI_DATA
);

  localparam int unsigned LANES  = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned DEPTH  = 1 << ADDRESS_WIDTH;
  localparam int unsigned CNT_W  = ADDRESS_WIDTH + 1;
  // Elements are widened by one bit so signed and unsigned share one multiplier.
  localparam int unsigned PROD_W = 2 * DATA_WIDTH + 2;
  localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
  localparam int unsigned EXT_W  = ((OUTPUT_WIDTH > SUM_W) ? OUTPUT_WIDTH : SUM_W) + 2;

  localparam logic [CNT_W-1:0]        DEPTH_LEN = CNT_W'(DEPTH);
  localparam logic signed [EXT_W-1:0] SMAX      = EXT_W'({(OUTPUT_WIDTH-1){1'b1}});
  localparam logic signed [EXT_W-1:0] SMIN      = ~SMAX;
  localparam logic signed [EXT_W-1:0] UMAX      = EXT_W'({OUTPUT_WIDTH{1'b1}});

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_W  = 3'd1;
  localparam logic [2:0] ST_LOAD_D  = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          len_q, len_c;
  logic                      signed_q;
  logic [BUS_WIDTH-1:0]      w_mem [DEPTH];
  logic [BUS_WIDTH-1:0]      d_mem [DEPTH];
  logic [BUS_WIDTH-1:0]      w_rd_q, d_rd_q;
  logic                      rd_valid_q;
  logic signed [SUM_W-1:0]   sum_q, lane_sum_c;
  logic                      sum_valid_q;
  logic [OUTPUT_WIDTH-1:0]   acc_q, acc_d, result_q, step_c;
  logic                      ovf_q, ovf_d, clamp_c;
  logic                      wack_q, dack_q, conv_q, busy_q;
  logic                      start_c, last_c;
  logic signed [DATA_WIDTH:0] wa, da;
  logic signed [EXT_W-1:0]   total_c;

  assign start_c = (state_q == ST_IDLE) && i_START;
  assign len_c   = (i_LEN > DEPTH_LEN) ? DEPTH_LEN : i_LEN;
  assign last_c  = (cnt_q == len_q - CNT_W'(1));

  // Next-state and word counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_START) begin
          cnt_d = '0;
          if (len_c == '0)         state_d = ST_DONE;
          else if (i_KEEP_WEIGHTS) state_d = ST_LOAD_D;
          else                     state_d = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (i_SPI_VALID) begin
          cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
          if (last_c) state_d = ST_LOAD_D;
        end
      end
      ST_LOAD_D: begin
        if (i_WISH_VALID) begin
          cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
          if (last_c) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        if (last_c) state_d = ST_DRAIN;
      end
      // Two cycles let the last address clear the read and sum stages.
      ST_DRAIN: begin
        cnt_d = (cnt_q == CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // LANES-way product sum of the registered buffer words.
  always_comb begin
    lane_sum_c = '0;
    wa = '0;
    da = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      wa = {signed_q & w_rd_q[j*DATA_WIDTH + DATA_WIDTH - 1], w_rd_q[j*DATA_WIDTH +: DATA_WIDTH]};
      da = {signed_q & d_rd_q[j*DATA_WIDTH + DATA_WIDTH - 1], d_rd_q[j*DATA_WIDTH +: DATA_WIDTH]};
      lane_sum_c = lane_sum_c + SUM_W'(wa * da);
    end
  end

  // Saturating accumulate step; the previous value is extended per mode.
  always_comb begin
    total_c = {{(EXT_W-OUTPUT_WIDTH){signed_q & acc_q[OUTPUT_WIDTH-1]}}, acc_q}
            + {{(EXT_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
    clamp_c = 1'b0;
    step_c  = OUTPUT_WIDTH'(total_c);
    if (signed_q) begin
      if (total_c > SMAX) begin
        step_c = OUTPUT_WIDTH'(SMAX); clamp_c = 1'b1;
      end else if (total_c < SMIN) begin
        step_c = OUTPUT_WIDTH'(SMIN); clamp_c = 1'b1;
      end
    end else begin
      if (total_c[EXT_W-1]) begin
        step_c = '0; clamp_c = 1'b1;
      end else if (total_c > UMAX) begin
        step_c = OUTPUT_WIDTH'(UMAX); clamp_c = 1'b1;
      end
    end
  end

  // Accumulator seeding on start, stepping on each valid lane sum.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (start_c) begin
      acc_d = i_ACC_CLEAR ? '0 : result_q;
      if (i_ACC_CLEAR) ovf_d = 1'b0;
    end else if (sum_valid_q) begin
      acc_d = step_c;
      if (clamp_c) ovf_d = 1'b1;
    end
  end

  // Control, pipeline and output registers.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      signed_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      wack_q      <= 1'b0;
      dack_q      <= 1'b0;
      conv_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (start_c) begin
        len_q    <= len_c;
        signed_q <= i_SIGNED;
      end
      rd_valid_q  <= (state_q == ST_COMPUTE);
      sum_valid_q <= rd_valid_q;
      sum_q       <= lane_sum_c;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      if (state_d == ST_DONE) result_q <= acc_d;
      wack_q      <= (state_d == ST_LOAD_W);
      dack_q      <= (state_d == ST_LOAD_D);
      conv_q      <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Buffers: no reset, contents undefined until loaded.
  always_ff @(posedge i_CLK) begin
    if (!i_RST && state_q == ST_LOAD_W && i_SPI_VALID)
      w_mem[cnt_q[ADDRESS_WIDTH-1:0]] <= i_SPI_DATA;
    if (!i_RST && state_q == ST_LOAD_D && i_WISH_VALID)
      d_mem[cnt_q[ADDRESS_WIDTH-1:0]] <= i_WISH_DATA;
    if (state_q == ST_COMPUTE) begin
      w_rd_q <= w_mem[cnt_q[ADDRESS_WIDTH-1:0]];
      d_rd_q <= d_mem[cnt_q[ADDRESS_WIDTH-1:0]];
    end
  end

  assign o_WEIGHT_ACK = wack_q;
  assign o_DATA_ACK   = dack_q;
  assign o_CONV_ACK   = conv_q;
  assign o_BUSY       = busy_q;
  assign o_OVF        = ovf_q;
  assign o_WISH_DATA  = result_q;
  assign o_SPI_DATA   = result_q;

endmodule

// File: doc/dsp_mac_array.md
Name: dsp_mac_array

Overview:
- Parametrised successor to the single-lane dsp convolution engine.
- Packs LANES = BUS_WIDTH/DATA_WIDTH elements per bus word and computes LANES products per cycle.
- Adds signed/unsigned mode, programmable vector length, weight reuse, accumulate-or-clear and saturating output.
- Weights arrive over SPI; data arrives over Wishbone. The result is driven on both output buses.

Parameters:
- BUS_WIDTH, 32, bus word width; must be a multiple of DATA_WIDTH.
- DATA_WIDTH, 8, element width. LANES = BUS_WIDTH/DATA_WIDTH.
- ADDRESS_WIDTH, 10, buffer address width. DEPTH = 2**ADDRESS_WIDTH words per buffer.
- OUTPUT_WIDTH, 32, accumulator and result width.

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  reset, synchronous, active-high.
- i_START  in  1  one-cycle command pulse; honoured only in IDLE.
- i_LEN  in  ADDRESS_WIDTH+1  vector length in words (0..DEPTH); sampled on i_START.
- i_SIGNED  in  1  1 = two's-complement elements and saturation; sampled on i_START.
- i_KEEP_WEIGHTS  in  1  1 = skip LOAD_W and reuse stored weights; sampled on i_START.
- i_ACC_CLEAR  in  1  1 = accumulator starts at 0; 0 = continue from previous result; sampled on i_START.
- i_SPI_VALID  in  1  weight word valid.
- i_SPI_DATA  in  BUS_WIDTH  weight word.
- i_WISH_VALID  in  1  data word valid.
- i_WISH_DATA  in  BUS_WIDTH  data word.
- o_WEIGHT_ACK  out  1  ready for a weight word.
- o_DATA_ACK  out  1  ready for a data word.
- o_CONV_ACK  out  1  one-cycle done pulse.
- o_BUSY  out  1  high whenever state is not IDLE.
- o_OVF  out  1  sticky saturation flag; cleared by i_RST or by a start with i_ACC_CLEAR=1.
- o_WISH_DATA  out  OUTPUT_WIDTH  result.
- o_SPI_DATA  out  OUTPUT_WIDTH  result (same value as o_WISH_DATA).

Behaviour:
- Reset (any state, including mid-operation):
  - state goes to IDLE;
  - all acks, o_BUSY and o_OVF go to 0; results go to 0;
  - word counter goes to 0;
  - buffer contents are left undefined.
- Transfer rule: a word transfers on the rising edge where VALID=1 and ACK=1. VALID without ACK is ignored. The VALID of the inactive port is ignored.
- States:
  - IDLE: on i_START, latch the config. Next state:
    - DONE if i_LEN=0;
    - LOAD_D if i_KEEP_WEIGHTS=1;
    - LOAD_W otherwise.
  - LOAD_W: o_WEIGHT_ACK=1. Weight word k is written to weight buffer address k. After i_LEN transfers, go to LOAD_D; ack drops the cycle after the last transfer.
  - LOAD_D: o_DATA_ACK=1. Same rules as LOAD_W, into the data buffer. After i_LEN transfers, go to COMPUTE.
  - COMPUTE: issue address k = 0..i_LEN-1, one per cycle. Pipeline stages:
    - registered buffer read;
    - registered LANES-way product sum;
    - accumulate.
  - DONE: o_CONV_ACK=1 for exactly one cycle, then return to IDLE.
- Latency: with C0 = first COMPUTE cycle, o_CONV_ACK is high in cycle C0+i_LEN+2. The result is valid in that cycle and is held until the next completion or reset.
- Lane j uses bits [j*DATA_WIDTH +: DATA_WIDTH]. Elements are sign- or zero-extended per i_SIGNED.
- Width: products are 2*DATA_WIDTH; the lane sum is 2*DATA_WIDTH+clog2(LANES); the accumulator is computed at OUTPUT_WIDTH+1 before clamping.
- Saturation: clamp every accumulate step to OUTPUT_WIDTH range (signed or unsigned per mode) and set o_OVF on each clamp. Later steps continue from the clamped value.
- i_LEN > DEPTH: clamp to DEPTH.
- i_LEN = 0: no loads, no compute. o_CONV_ACK occurs 1 cycle after i_START; the result is 0 (clear) or unchanged.
- i_START while o_BUSY=1: ignored; the latched config is unchanged.
- i_KEEP_WEIGHTS with a longer i_LEN than the last weight load: reads stale or undefined weights; no error is flagged.

Test Plan:
- Unsigned, i_LEN=1024, clear. Weights 0x01010101 ×1024, data 0x02020202 ×1024 -> o_CONV_ACK pulse at C0+1026; result 0x00002000; o_OVF=0.
- Immediately follow with a start using keep-weights and accumulate (no clear). Data 0x03030303 ×1024 -> o_WEIGHT_ACK never rises; result 0x00005000.
- Signed, i_LEN=4, clear. Weights 0xFFFFFFFF, data 0x02020202 -> result 0xFFFFFFE0 (−32).
- OUTPUT_WIDTH=16 instance, unsigned, i_LEN=2. All 0xFFFFFFFF -> result 0xFFFF; o_OVF=1. A following clear start with small data clears o_OVF.
- Handshake: i_WISH_VALID toggled randomly during LOAD_W and i_SPI_VALID held high during LOAD_D -> no stray writes; transfer counts exact. i_START during LOAD_D is ignored.
- i_LEN=0 -> o_CONV_ACK pulse 1 cycle after i_START; no ack asserted. Assert i_RST mid-LOAD_D -> next cycle o_DATA_ACK=0, o_BUSY=0, results 0.
